fw_dnn_capture: RTL and testbench

//  DUT-to-FW receive path for the CMS pixel test IP: captures the DUT DNN outputs (fw_dnn_output_0/1)

---
 rtl/fw_dnn_capture_if.sv | 26 ++
 rtl/fw_dnn_capture.sv | 204 ++++++++++++++++++++
 tb/tb_fw_dnn_capture.sv | 291 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/fw_dnn_capture_if.sv
// Control and readout bus of the DNN capture block.
// The FW/SW side uses the master modport. The capture block uses the slave modport.
interface fw_dnn_capture_if #(
    parameter int ADDR_W = 8
);
    logic              fw_dev_id_enable;
    logic              arm;
    logic [ADDR_W-1:0] num_words;
    logic [5:0]        sample_delay;
    logic              rd_sel;
    logic [ADDR_W-1:0] rd_addr;
    logic [31:0]       rd_data32;
    logic              busy;
    logic              done;
    logic [7:0]        status8;

    modport master (
        output fw_dev_id_enable, arm, num_words, sample_delay, rd_sel, rd_addr,
        input  rd_data32, busy, done, status8
    );

    modport slave (
        input  fw_dev_id_enable, arm, num_words, sample_delay, rd_sel, rd_addr,
        output rd_data32, busy, done, status8
    );
endinterface

// File: rtl/fw_dnn_capture.sv
// DUT-to-FW receive path: samples the two DUT DNN output bits once per bxclk
// period after a DUT event. Bits are packed LSB first into 16-bit words in
// two parallel buffers, and the buffers are read back as 32-bit word pairs.
module fw_dnn_capture #(
    parameter int DEPTH       = 256,
    parameter int ADDR_W      = 8,
    parameter int SYNC_STAGES = 2
) (
    input  logic            fw_pl_clk1,
    input  logic            fw_rst,
    input  logic            fw_bxclk,
    input  logic            fw_dnn_output_0,
    input  logic            fw_dnn_output_1,
    input  logic            fw_dn_event_toggle,
    fw_dnn_capture_if.slave cap
);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        WAIT_EVT = 2'd1,
        CAPTURE  = 2'd2,
        DONE_ST  = 2'd3
    } state_t;

    localparam logic [ADDR_W:0] DEPTH_W = (ADDR_W + 1)'(DEPTH);

    state_t state, state_nxt;

    logic [SYNC_STAGES-1:0] dnn0_sync, dnn1_sync, tog_sync;
    logic                   dnn0_s, dnn1_s, tog_s;
    logic                   tog_d, bxclk_d;
    logic                   evt, bx_rise;

    logic                   pending;
    logic [5:0]             dly_cnt;
    logic [3:0]             bit_cnt;
    logic [ADDR_W:0]        word_cnt;
    logic [ADDR_W-1:0]      wr_ptr;
    logic [15:0]            sr0, sr1;
    logic [15:0]            word0_nxt, word1_nxt;

    logic                   done_r, aborted_r, late_r, arm_err_r;
    logic [3:0]             evt_cnt;

    logic                   enable, cap_active, accept_arm, abort_now;
    logic                   take_late, take_zero, take_dly, take;
    logic                   word_done, last_word, busy_c;
    logic [ADDR_W:0]        words_target;
    logic [ADDR_W-1:0]      rd_addr_p1;

    logic [15:0]            mem0 [DEPTH];
    logic [15:0]            mem1 [DEPTH];

    // Metastability synchronizers on the asynchronous DUT pins, plus edge-detect history
    always_ff @(posedge fw_pl_clk1 or posedge fw_rst) begin
        if (fw_rst) begin
            dnn0_sync <= '0;
            dnn1_sync <= '0;
            tog_sync  <= '0;
            tog_d     <= 1'b0;
            bxclk_d   <= 1'b0;
        end else begin
            dnn0_sync <= {dnn0_sync[SYNC_STAGES-2:0], fw_dnn_output_0};
            dnn1_sync <= {dnn1_sync[SYNC_STAGES-2:0], fw_dnn_output_1};
            tog_sync  <= {tog_sync[SYNC_STAGES-2:0], fw_dn_event_toggle};
            tog_d     <= tog_s;
            bxclk_d   <= fw_bxclk;
        end
    end

    // Control decode shared by the FSM, the sampler and the flags
    always_comb begin
        dnn0_s       = dnn0_sync[SYNC_STAGES-1];
        dnn1_s       = dnn1_sync[SYNC_STAGES-1];
        tog_s        = tog_sync[SYNC_STAGES-1];
        evt          = tog_s ^ tog_d;
        bx_rise      = fw_bxclk & ~bxclk_d;
        enable       = cap.fw_dev_id_enable;
        accept_arm   = cap.arm & enable & (state == IDLE);
        abort_now    = ~enable & ((state == WAIT_EVT) | (state == CAPTURE));
        cap_active   = enable & (state == CAPTURE);
        // A rise with a sample still outstanding takes that sample immediately.
        take_late    = cap_active & bx_rise & pending;
        take_zero    = cap_active & bx_rise & (cap.sample_delay == 6'd0);
        take_dly     = cap_active & ~bx_rise & pending & (dly_cnt == cap.sample_delay);
        take         = take_late | take_zero | take_dly;
        word0_nxt    = {dnn0_s, sr0[15:1]};
        word1_nxt    = {dnn1_s, sr1[15:1]};
        word_done    = take & (bit_cnt == 4'hF);
        words_target = (cap.num_words == '0) ? DEPTH_W : {1'b0, cap.num_words};
        last_word    = word_done & ((word_cnt + (ADDR_W + 1)'(1)) == words_target);
        rd_addr_p1   = cap.rd_addr + ADDR_W'(1);
    end

    // FSM state register
    always_ff @(posedge fw_pl_clk1 or posedge fw_rst) begin
        if (fw_rst) state <= IDLE;
        else        state <= state_nxt;
    end

    // FSM next-state and busy output
    always_comb begin
        state_nxt = state;
        busy_c    = (state != IDLE);
        case (state)
            IDLE:     if (accept_arm) state_nxt = WAIT_EVT;
            WAIT_EVT: begin
                if (!enable)  state_nxt = IDLE;
                else if (evt) state_nxt = CAPTURE;
            end
            CAPTURE:  begin
                if (!enable)        state_nxt = IDLE;
                else if (last_word) state_nxt = DONE_ST;
            end
            DONE_ST:  state_nxt = IDLE;
            default:  state_nxt = IDLE;
        endcase
    end

    // Sample-point timer: restarts on every bxclk rise and counts ticks toward sample_delay
    always_ff @(posedge fw_pl_clk1 or posedge fw_rst) begin
        if (fw_rst) begin
            pending <= 1'b0;
            dly_cnt <= '0;
        end else if (!cap_active) begin
            pending <= 1'b0;
            dly_cnt <= '0;
        end else if (bx_rise) begin
            // The rise cycle is tick 0, so the next cycle is tick 1.
            pending <= (cap.sample_delay != 6'd0);
            dly_cnt <= 6'd1;
        end else if (pending) begin
            if (dly_cnt == cap.sample_delay) pending <= 1'b0;
            else                             dly_cnt <= dly_cnt + 6'd1;
        end
    end

    // Bit packing into words plus write pointer and word count
    always_ff @(posedge fw_pl_clk1 or posedge fw_rst) begin
        if (fw_rst) begin
            sr0      <= '0;
            sr1      <= '0;
            bit_cnt  <= '0;
            word_cnt <= '0;
            wr_ptr   <= '0;
        end else if (accept_arm) begin
            bit_cnt  <= '0;
            word_cnt <= '0;
            wr_ptr   <= '0;
        end else if (take) begin
            sr0     <= word0_nxt;
            sr1     <= word1_nxt;
            bit_cnt <= bit_cnt + 4'd1;
            if (bit_cnt == 4'hF) begin
                wr_ptr   <= wr_ptr + ADDR_W'(1);
                word_cnt <= word_cnt + (ADDR_W + 1)'(1);
            end
        end
    end

    // Word buffers: both are written in parallel when a word completes, and they are never cleared
    always_ff @(posedge fw_pl_clk1) begin
        if (word_done) begin
            mem0[wr_ptr] <= word0_nxt;
            mem1[wr_ptr] <= word1_nxt;
        end
    end

    // Registered 32-bit readout of the word pair at rd_addr (wrapping) from the selected buffer
    always_ff @(posedge fw_pl_clk1 or posedge fw_rst) begin
        if (fw_rst)          cap.rd_data32 <= '0;
        else if (cap.rd_sel) cap.rd_data32 <= {mem1[rd_addr_p1], mem1[cap.rd_addr]};
        else                 cap.rd_data32 <= {mem0[rd_addr_p1], mem0[cap.rd_addr]};
    end

    // Sticky status flags, cleared together by an accepted arm
    always_ff @(posedge fw_pl_clk1 or posedge fw_rst) begin
        if (fw_rst) begin
            done_r    <= 1'b0;
            aborted_r <= 1'b0;
            late_r    <= 1'b0;
            arm_err_r <= 1'b0;
            evt_cnt   <= '0;
        end else if (accept_arm) begin
            done_r    <= 1'b0;
            aborted_r <= 1'b0;
            late_r    <= 1'b0;
            arm_err_r <= 1'b0;
            evt_cnt   <= '0;
        end else begin
            if (cap.arm && busy_c)    arm_err_r <= 1'b1;
            if (state == DONE_ST)     done_r    <= 1'b1;
            if (abort_now)            aborted_r <= 1'b1;
            if (take_late)            late_r    <= 1'b1;
            if (cap_active && evt && (evt_cnt != 4'hF))
                evt_cnt <= evt_cnt + 4'd1;
        end
    end

    assign cap.busy    = busy_c;
    assign cap.done    = done_r;
    assign cap.status8 = {evt_cnt, late_r, aborted_r, arm_err_r, done_r};

endmodule

// File: tb/tb_fw_dnn_capture.sv
// Self-checking bench for fw_dnn_capture. A word-level reference model is built
// from the driven bit streams: bit n of a capture lands in word n/16, bit n%16.
module tb_fw_dnn_capture;

    logic fw_pl_clk1;
    logic fw_rst;
    logic bxclk, dnn0, dnn1, tog;

    fw_dnn_capture_if #(.ADDR_W(8)) ifc ();

    fw_dnn_capture #(.DEPTH(256), .ADDR_W(8), .SYNC_STAGES(2)) dut (
        .fw_pl_clk1         (fw_pl_clk1),
        .fw_rst             (fw_rst),
        .fw_bxclk           (bxclk),
        .fw_dnn_output_0    (dnn0),
        .fw_dnn_output_1    (dnn1),
        .fw_dn_event_toggle (tog),
        .cap                (ifc)
    );

    int n_pass;
    int n_total;
    bit s0[$];
    bit s1[$];
    logic [15:0] m0 [256];
    logic [15:0] m1 [256];

    initial begin
        fw_pl_clk1 = 1'b0;
        forever #5 fw_pl_clk1 = ~fw_pl_clk1;
    end

    initial begin
        #3ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    // Expected word k of a buffer, taken straight from the driven stream
    function automatic logic [15:0] exp_word(input bit sel, input int k);
        logic [15:0] w;
        for (int j = 0; j < 16; j++) w[j] = sel ? s1[16*k+j] : s0[16*k+j];
        return w;
    endfunction

    task automatic commit_words(input int nw);
        for (int k = 0; k < nw; k++) begin
            m0[k % 256] = exp_word(1'b0, k);
            m1[k % 256] = exp_word(1'b1, k);
        end
    endtask

    task automatic fill_random(input int nbits);
        s0.delete();
        s1.delete();
        for (int i = 0; i < nbits; i++) begin
            s0.push_back(1'($urandom));
            s1.push_back(1'($urandom));
        end
    endtask

    task automatic start_capture(input logic [7:0] nw, input logic [5:0] dly);
        @(negedge fw_pl_clk1);
        ifc.num_words = nw;
        ifc.sample_delay = dly;
        ifc.arm = 1'b1;
        @(negedge fw_pl_clk1);
        ifc.arm = 1'b0;
        repeat (2) @(negedge fw_pl_clk1);
        tog = ~tog;
        repeat (8) @(negedge fw_pl_clk1);
    endtask

    // One bxclk period per rise. The stream bit for that period is presented at the rise.
    task automatic drive_stream(input int period, input int base, input int nrises,
                                input int arm_at, input int evt_a, input int evt_b);
        int h;
        h = period / 2;
        for (int i = 0; i < nrises; i++) begin
            @(negedge fw_pl_clk1);
            bxclk = 1'b1;
            dnn0 = (base + i < s0.size()) ? s0[base+i] : 1'($urandom);
            dnn1 = (base + i < s1.size()) ? s1[base+i] : 1'($urandom);
            if (i == arm_at) ifc.arm = 1'b1;
            if (i == evt_a || i == evt_b) tog = ~tog;
            repeat (h) begin
                @(negedge fw_pl_clk1);
                ifc.arm = 1'b0;
            end
            bxclk = 1'b0;
            repeat (period - h - 1) @(negedge fw_pl_clk1);
        end
    endtask

    task automatic read32(input logic sel, input logic [7:0] addr, output logic [31:0] d);
        @(negedge fw_pl_clk1);
        ifc.rd_sel = sel;
        ifc.rd_addr = addr;
        @(negedge fw_pl_clk1);
        d = ifc.rd_data32;
    endtask

    task automatic wait_done(input int budget);
        for (int i = 0; i < budget && ifc.done !== 1'b1; i++) @(negedge fw_pl_clk1);
    endtask

    task automatic test_reset();
        fw_rst = 1'b1;
        repeat (3) @(negedge fw_pl_clk1);
        n_total++; if (ifc.rd_data32 !== 32'h0) $display("FAIL reset_rd_data32: got %h expected 00000000", ifc.rd_data32); else n_pass++;
        n_total++; if (ifc.busy !== 1'b0) $display("FAIL reset_busy: got %b expected 0", ifc.busy); else n_pass++;
        n_total++; if (ifc.status8 !== 8'h00) $display("FAIL reset_status8: got %h expected 00", ifc.status8); else n_pass++;
        fw_rst = 1'b0;
        repeat (3) @(negedge fw_pl_clk1);
        ifc.fw_dev_id_enable = 1'b0;
        ifc.arm = 1'b1;
        @(negedge fw_pl_clk1);
        ifc.arm = 1'b0;
        repeat (3) @(negedge fw_pl_clk1);
        n_total++; if (ifc.busy !== 1'b0) $display("FAIL disabled_arm_busy: got %b expected 0", ifc.busy); else n_pass++;
        n_total++; if (ifc.status8 !== 8'h00) $display("FAIL disabled_arm_status8: got %h expected 00", ifc.status8); else n_pass++;
        ifc.fw_dev_id_enable = 1'b1;
    endtask

    task automatic test_single_word();
        logic [15:0] pat;
        logic [31:0] d;
        int nw;
        logic [5:0] dly;
        pat = 16'hA5C3;
        s0.delete();
        s1.delete();
        for (int j = 0; j < 16; j++) begin
            s0.push_back(pat[j]);
            s1.push_back(1'b1);
        end
        start_capture(8'd1, 6'd3);
        n_total++; if (ifc.busy !== 1'b1) $display("FAIL single_busy: got %b expected 1", ifc.busy); else n_pass++;
        drive_stream(10, 0, 16, -1, -1, -1);
        wait_done(20);
        n_total++; if (ifc.status8 !== 8'h01) $display("FAIL single_status8: got %h expected 01", ifc.status8); else n_pass++;
        commit_words(1);
        read32(1'b0, 8'd0, d);
        n_total++; if (d[15:0] !== 16'hA5C3) $display("FAIL single_buf0: got %h expected a5c3", d[15:0]); else n_pass++;
        read32(1'b1, 8'd0, d);
        n_total++; if (d[15:0] !== 16'hFFFF) $display("FAIL single_buf1: got %h expected ffff", d[15:0]); else n_pass++;

        nw = 3;
        dly = 6'($urandom_range(2, 9));
        fill_random(16 * nw);
        start_capture(8'(nw), dly);
        drive_stream(10, 0, 16 * nw, -1, -1, -1);
        wait_done(20);
        n_total++; if (ifc.done !== 1'b1) $display("FAIL multi_done: got %b expected 1 (delay %0d)", ifc.done, dly); else n_pass++;
        commit_words(nw);
        for (int s = 0; s < 2; s++) begin
            read32(1'(s), 8'd0, d);
            n_total++;
            if (d !== (s != 0 ? {m1[1], m1[0]} : {m0[1], m0[0]}))
                $display("FAIL multi_rd_sel%0d_addr0: got %h expected %h", s, d, (s != 0 ? {m1[1], m1[0]} : {m0[1], m0[0]}));
            else n_pass++;
            read32(1'(s), 8'd1, d);
            n_total++;
            if (d !== (s != 0 ? {m1[2], m1[1]} : {m0[2], m0[1]}))
                $display("FAIL multi_rd_sel%0d_addr1: got %h expected %h", s, d, (s != 0 ? {m1[2], m1[1]} : {m0[2], m0[1]}));
            else n_pass++;
        end
    endtask

    task automatic test_full_depth();
        logic [31:0] d;
        logic [31:0] e;
        logic [7:0] a;
        logic sel;
        fill_random(16 * 256);
        start_capture(8'd0, 6'd2);
        drive_stream(4, 0, 16 * 255, -1, -1, -1);
        n_total++; if (ifc.busy !== 1'b1) $display("FAIL full_busy_at_255: got %b expected 1", ifc.busy); else n_pass++;
        n_total++; if (ifc.done !== 1'b0) $display("FAIL full_done_at_255: got %b expected 0", ifc.done); else n_pass++;
        drive_stream(4, 16 * 255, 16, -1, -1, -1);
        wait_done(20);
        n_total++; if (ifc.status8 !== 8'h01) $display("FAIL full_status8: got %h expected 01", ifc.status8); else n_pass++;
        commit_words(256);
        read32(1'b0, 8'd255, d);
        n_total++; if (d !== {m0[0], m0[255]}) $display("FAIL full_wrap_buf0: got %h expected %h", d, {m0[0], m0[255]}); else n_pass++;
        read32(1'b1, 8'd255, d);
        n_total++; if (d !== {m1[0], m1[255]}) $display("FAIL full_wrap_buf1: got %h expected %h", d, {m1[0], m1[255]}); else n_pass++;
        for (int r = 0; r < 6; r++) begin
            a = 8'($urandom_range(0, 254));
            sel = 1'($urandom);
            e = sel ? {m1[a+1], m1[a]} : {m0[a+1], m0[a]};
            read32(sel, a, d);
            n_total++; if (d !== e) $display("FAIL full_rd sel=%0d addr=%0d: got %h expected %h", sel, a, d, e); else n_pass++;
        end
    endtask

    task automatic test_arm_while_busy();
        logic [15:0] pat;
        logic [31:0] d;
        pat = 16'hA5C3;
        s0.delete();
        s1.delete();
        for (int j = 0; j < 16; j++) begin
            s0.push_back(pat[j]);
            s1.push_back(1'b1);
        end
        start_capture(8'd1, 6'd3);
        drive_stream(10, 0, 16, 4, -1, -1);
        wait_done(20);
        n_total++; if (ifc.status8 !== 8'h03) $display("FAIL busy_arm_status8: got %h expected 03", ifc.status8); else n_pass++;
        commit_words(1);
        read32(1'b0, 8'd0, d);
        n_total++; if (d !== {m0[1], 16'hA5C3}) $display("FAIL busy_arm_buf0: got %h expected %h", d, {m0[1], 16'hA5C3}); else n_pass++;
        read32(1'b1, 8'd0, d);
        n_total++; if (d !== {m1[1], 16'hFFFF}) $display("FAIL busy_arm_buf1: got %h expected %h", d, {m1[1], 16'hFFFF}); else n_pass++;
    endtask

    task automatic test_abort();
        logic [31:0] d;
        fill_random(64);
        start_capture(8'd4, 6'd3);
        n_total++; if (ifc.status8[1] !== 1'b0) $display("FAIL abort_armerr_cleared: got %b expected 0", ifc.status8[1]); else n_pass++;
        drive_stream(10, 0, 20, -1, -1, -1);
        ifc.fw_dev_id_enable = 1'b0;
        repeat (2) @(negedge fw_pl_clk1);
        n_total++; if (ifc.busy !== 1'b0) $display("FAIL abort_busy: got %b expected 0", ifc.busy); else n_pass++;
        n_total++; if (ifc.status8 !== 8'h04) $display("FAIL abort_status8: got %h expected 04", ifc.status8); else n_pass++;
        ifc.fw_dev_id_enable = 1'b1;
        // Only word 0 completed; word 1 keeps its previous contents.
        commit_words(1);
        read32(1'b0, 8'd0, d);
        n_total++; if (d !== {m0[1], m0[0]}) $display("FAIL abort_buf0: got %h expected %h", d, {m0[1], m0[0]}); else n_pass++;
        read32(1'b1, 8'd0, d);
        n_total++; if (d !== {m1[1], m1[0]}) $display("FAIL abort_buf1: got %h expected %h", d, {m1[1], m1[0]}); else n_pass++;

        start_capture(8'd4, 6'd3);
        drive_stream(10, 0, 5, -1, -1, -1);
        fw_rst = 1'b1;
        #1;
        n_total++; if (ifc.busy !== 1'b0) $display("FAIL midrst_busy: got %b expected 0", ifc.busy); else n_pass++;
        n_total++; if (ifc.status8 !== 8'h00) $display("FAIL midrst_status8: got %h expected 00", ifc.status8); else n_pass++;
        n_total++; if (ifc.rd_data32 !== 32'h0) $display("FAIL midrst_rd_data32: got %h expected 00000000", ifc.rd_data32); else n_pass++;
        repeat (3) @(negedge fw_pl_clk1);
        fw_rst = 1'b0;
        repeat (6) @(negedge fw_pl_clk1);
    endtask

    task automatic test_late_sample();
        logic [31:0] d;
        fill_random(32);
        start_capture(8'd2, 6'd12);
        // Each pending sample is taken on the following rise, so one extra rise closes the last bit.
        drive_stream(10, 0, 33, -1, 5, 10);
        wait_done(20);
        n_total++; if (ifc.status8 !== 8'h29) $display("FAIL late_status8: got %h expected 29", ifc.status8); else n_pass++;
        commit_words(2);
        read32(1'b0, 8'd0, d);
        n_total++; if (d !== {m0[1], m0[0]}) $display("FAIL late_buf0: got %h expected %h", d, {m0[1], m0[0]}); else n_pass++;
        read32(1'b1, 8'd0, d);
        n_total++; if (d !== {m1[1], m1[0]}) $display("FAIL late_buf1: got %h expected %h", d, {m1[1], m1[0]}); else n_pass++;
    endtask

    initial begin
        n_pass = 0;
        n_total = 0;
        fw_rst = 1'b1;
        bxclk = 1'b0;
        dnn0 = 1'b0;
        dnn1 = 1'b0;
        tog = 1'b0;
        ifc.fw_dev_id_enable = 1'b1;
        ifc.arm = 1'b0;
        ifc.num_words = '0;
        ifc.sample_delay = '0;
        ifc.rd_sel = 1'b0;
        ifc.rd_addr = '0;
        for (int i = 0; i < 256; i++) begin
            m0[i] = 'x;
            m1[i] = 'x;
        end
        test_reset();
        test_single_word();
        test_full_depth();
        test_arm_while_busy();
        test_abort();
        test_late_sample();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
